// File: rtl/ext_ram_responder.sv
// Block-RAM responder for the WR core external RAM port with a host firmware-load port.
// Optional load checksum enabled by defining EXT_RAM_RESPONDER_CHECKSUM_EN.
module ext_ram_responder #(
    parameter int          DEPTH_WORDS    = 32768,
    parameter int          RELEASE_CYCLES = 16,
    parameter logic [31:0] OOB_DATA       = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] ext_ram_adr,
    output logic [31:0] ext_ram_dat_r,
    input  logic        ld_start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_adr,
    input  logic [31:0] ld_dat,
    input  logic [3:0]  ld_sel,
    input  logic        ld_last,
    output logic [31:0] ld_words,
    output logic [31:0] ld_checksum,
    output logic        core_rst,
    output logic        oob_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [1:0] {LOAD, RELEASE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] rel_cnt;
    logic          fresh;
    logic          load_open, accept, rel_done, restart;
    logic          rd_oob, wr_oob;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [31:0]   mem [DEPTH_WORDS];

    // Byte-offset bits of word-aligned addresses carry no information.
    logic unused_bits;
    assign unused_bits = ^{ext_ram_adr[1:0], ld_adr[1:0]};

    assign rd_oob    = |ext_ram_adr[31:AW+2];
    assign wr_oob    = |ld_adr[31:AW+2];
    assign rd_idx    = ext_ram_adr[AW+1:2];
    assign wr_idx    = ld_adr[AW+1:2];
    // Loading is closed in the cycle following a reset edge and while reset is held.
    assign load_open = (state == LOAD) && !fresh && !sys_rst;
    assign accept    = ld_valid && load_open;
    assign rel_done  = (rel_cnt == CW'(RELEASE_CYCLES - 1));
    assign restart   = ld_start && (state != LOAD);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= LOAD;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        core_rst  = 1'b1;
        case (state)
            LOAD: begin
                ld_ready = load_open;
                if (accept && ld_last) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (ld_start)      state_nxt = LOAD;
                else if (rel_done) state_nxt = RUN;
            end
            RUN: begin
                core_rst = 1'b0;
                if (ld_start) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fresh   <= 1'b1;
            rel_cnt <= '0;
        end else begin
            fresh <= 1'b0;
            if (state != RELEASE) rel_cnt <= '0;
            else                  rel_cnt <= rel_cnt + CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ext_ram_dat_r <= OOB_DATA;
            oob_err       <= 1'b0;
            ld_words      <= '0;
        end else begin
            ext_ram_dat_r <= OOB_DATA;
            if (state == RUN) begin
                if (rd_oob) oob_err       <= 1'b1;
                else        ext_ram_dat_r <= mem[rd_idx];
            end
            if (accept) begin
                ld_words <= ld_words + 32'd1;
                if (wr_oob) oob_err <= 1'b1;
            end
            if (restart) ld_words <= '0;
        end
    end

    // RAM is never reset so a reset mid-session keeps already written beats.
    always_ff @(posedge sys_clk) begin
        if (accept && !wr_oob) begin
            for (int i = 0; i < 4; i++)
                if (ld_sel[i]) mem[wr_idx][8*i +: 8] <= ld_dat[8*i +: 8];
        end
    end

`ifdef EXT_RAM_RESPONDER_CHECKSUM_EN
    logic [31:0] csum;
    always_ff @(posedge sys_clk) begin
        if (sys_rst || restart) csum <= '0;
        else if (accept)        csum <= csum + ld_dat;
    end
    assign ld_checksum = csum;
`else
    assign ld_checksum = 32'h0;
`endif

endmodule

// File: doc/ext_ram_responder.md
Name: ext_ram_responder

Overview:
- Memory-side responder for the WR soft-core external RAM port: word-addressed block RAM that serves core instruction/data fetches with registered read data.
- Also provides a host firmware-load port (valid/ready) that writes RAM while holding the core in reset, then releases the core after a fixed delay.
- Sits behind the RAM tap on the core side; the load port is driven by the LiteX SoC.

Parameters:
- DEPTH_WORDS, 32768, RAM depth in 32-bit words (power of two); AW = log2(DEPTH_WORDS).
- RELEASE_CYCLES, 16, cycles core_rst stays high after the last load beat (>=1).
- OOB_DATA, 32'h0000_0000, read data returned for out-of-range addresses and during LOAD/RELEASE.

Ports:
- sys_clk  in  1  single clock, all logic rising-edge.
- sys_rst  in  1  synchronous, active-high reset.
- ext_ram_adr  in  32  byte address from core; word index = ext_ram_adr[AW+1:2].
- ext_ram_dat_r  out  32  read data, one cycle after the address.
- ld_start  in  1  single-cycle pulse that starts a load session.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready.
- ld_adr  in  32  load byte address (word aligned; bits [1:0] ignored).
- ld_dat  in  32  load write data.
- ld_sel  in  4  byte enables; bit i writes ld_dat[8i+7:8i].
- ld_last  in  1  marks the final beat of the session.
- ld_words  out  32  beats accepted in the current or last session.
- ld_checksum  out  32  load checksum (see Optional Feature).
- core_rst  out  1  hold-reset for the WR core.
- oob_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (sys_rst=1 at an edge): state=LOAD, core_rst=1, ld_ready=0 for that cycle, ld_words=0, ld_checksum=0, oob_err=0, release counter=0, ext_ram_dat_r=OOB_DATA. RAM contents are not cleared.
- FSM states:
  - LOAD: core_rst=1; ld_ready=1 except in the reset cycle. Each accepted beat writes the selected bytes and increments ld_words (wraps at 2^32). An accepted beat with ld_last=1 clears the counter and moves to RELEASE.
  - RELEASE: core_rst=1, ld_ready=0. Counter increments each cycle; at count RELEASE_CYCLES-1 the FSM goes to RUN. core_rst falls exactly RELEASE_CYCLES cycles after the ld_last acceptance edge.
  - RUN: core_rst=0, ld_ready=0. Reads are served.
- ld_start handling:
  - In RUN or RELEASE: go to LOAD next cycle; clear ld_words and ld_checksum; core_rst=1 from that cycle on.
  - In LOAD: ignored.
  - ld_start with sys_rst: reset wins.
- Reads:
  - In RUN, ext_ram_dat_r at cycle N+1 = RAM[word index of ext_ram_adr at cycle N].
  - If ext_ram_adr[31:AW+2] != 0, data = OOB_DATA and oob_err is set.
  - In LOAD/RELEASE, ext_ram_dat_r = OOB_DATA and no oob_err.
- Writes:
  - Occur only in LOAD, so there is no read/write collision.
  - A beat with ld_adr[31:AW+2] != 0 is accepted and counted, but the RAM is not written and oob_err is set.
  - ld_sel=0 is a counted no-op write.
- oob_err clears only on sys_rst.
- Reset mid-LOAD or mid-RELEASE: returns to LOAD; beats already written remain in RAM.

Optional Feature:
- Macro EXT_RAM_RESPONDER_CHECKSUM_EN.
- Defined: ld_checksum = mod-2^32 sum of ld_dat over all accepted beats, including OOB beats and regardless of ld_sel. Updated the cycle after acceptance; cleared on reset and ld_start.
- Undefined: ld_checksum tied to 0; no adder is synthesized.

Test Plan:
- Reset, then 3 beats to 0x0,0x4,0x8 with data 0x11111111,0x22222222,0x33333333, sel=0xF, last on the third -> ld_words=3; core_rst falls 16 cycles after the third beat; in RUN, adr=0x4 gives dat_r=0x22222222 the next cycle.
- Load 0xAABBCCDD to 0x10 sel=0xF, then 0x00000099 to 0x10 sel=0x1 last -> RUN read of 0x10 returns 0xAABBCC99.
- In RUN, read adr=0x0002_0000 (DEPTH 32768) -> dat_r=0x00000000, oob_err=1 and stays 1 through a later ld_start session until sys_rst.
- In RUN, pulse ld_start -> core_rst=1 next cycle, ld_words=0; stall ld_valid 5 cycles -> no writes; ld_start again in LOAD is ignored.
- Assert sys_rst during RELEASE (counter at 7) -> state LOAD, core_rst stays 1, previously loaded data readable after the next load session.
- With EXT_RAM_RESPONDER_CHECKSUM_EN, beats 0xFFFFFFFF and 0x00000002 -> ld_checksum=0x00000001; without the macro -> 0.
